fma16_unpack: RTL and testbench

- Operand-side counterpart to the FMA16 rounding/packing stage.
- Accepts a packed IEEE-754 binary16 operand and classifies it. Emits sign, unbiased signed exponent and an explicit-leading-one mantissa to the FMA datapath.
- Subnormals are normalized iteratively, one bit per cycle, so output latency is variable. A valid/ready handshake on both sides absorbs this.

---
 rtl/fma16_pkg.sv | 17 +
 rtl/fma16_lzc.sv | 18 +
 rtl/fma16_unpack.sv | 130 +++++++++++++
 tb/tb_fma16_unpack.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// Shared constants and types for the FMA16 operand unpack path.
package fma16_pkg;
    localparam int NE      = 5;
    localparam int NF      = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    typedef struct packed {
        logic is_zero;
        logic is_sub;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp16_class_t;

    typedef enum logic [1:0] {IDLE, NORM, DONE} unpack_state_t;
endpackage

// File: rtl/fma16_lzc.sv
// Leading-zero counter over the (NF+1)-bit mantissa; an all-zero input reports NF+1.
module fma16_lzc
    import fma16_pkg::*;
#(
    parameter int W  = NF + 1,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a,
    output logic [CW-1:0] cnt
);
    // Ascending scan: the highest set bit is visited last, so its count wins.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (a[i]) cnt = CW'(W - 1 - i);
        end
    end
endmodule

// File: rtl/fma16_unpack.sv
// Unpacks and classifies a binary16 operand behind valid/ready handshakes.
// Define FMA16_UNPACK_LZC_EN to normalize subnormals in one cycle (LZC + barrel shift).
module fma16_unpack
    import fma16_pkg::*;
#(
    parameter int NE  = fma16_pkg::NE,
    parameter int NF  = fma16_pkg::NF,
    parameter int XEW = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NE+NF:0]   x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             xs,
    output logic [XEW-1:0]   xe,
    output logic [NF:0]      xm,
    output logic             is_zero,
    output logic             is_sub,
    output logic             is_inf,
    output logic             is_nan,
    output logic             is_snan
);
    unpack_state_t state;
    fp16_class_t   cls;

    logic [NE-1:0]  e_fld;
    logic [NF-1:0]  f_fld;
    fp16_class_t    c_cls;
    logic [XEW-1:0] c_xe;
    logic [NF:0]    c_xm;
    logic           c_norm;
    logic           accept;

    assign e_fld    = x[NE+NF-1:NF];
    assign f_fld    = x[NF-1:0];
    // A DONE result that is leaving this edge frees the slot for a new operand.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

`ifdef FMA16_UNPACK_LZC_EN
    logic [$clog2(NF+2)-1:0] lz;

    fma16_lzc u_lzc (
        .a   ({1'b0, f_fld}),
        .cnt (lz)
    );
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        c_cls  = '0;
        c_xe   = '0;
        c_xm   = '0;
        c_norm = 1'b0;
        if (e_fld == '0) begin
            if (f_fld == '0) begin
                c_cls.is_zero = 1'b1;
            end else begin
                c_cls.is_sub = 1'b1;
`ifdef FMA16_UNPACK_LZC_EN
                c_xm = {1'b0, f_fld} << lz;
                c_xe = XEW'(1 - BIAS) - XEW'(lz);
`else
                c_xm   = {1'b0, f_fld};
                c_xe   = XEW'(1 - BIAS);
                c_norm = 1'b1;
`endif
            end
        end else if (e_fld == NE'(EXP_MAX)) begin
            c_xe = XEW'(EXP_MAX - BIAS);
            c_xm = {1'b0, f_fld};
            if (f_fld == '0) begin
                c_cls.is_inf = 1'b1;
            end else begin
                c_cls.is_nan  = 1'b1;
                c_cls.is_snan = ~f_fld[NF-1];
            end
        end else begin
            c_xe = XEW'(e_fld) - XEW'(BIAS);
            c_xm = {1'b1, f_fld};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            xs        <= 1'b0;
            xe        <= '0;
            xm        <= '0;
            cls       <= '0;
        end else if (accept) begin
            xs        <= x[NE+NF];
            xe        <= c_xe;
            xm        <= c_xm;
            cls       <= c_cls;
            state     <= c_norm ? NORM : DONE;
            out_valid <= ~c_norm;
        end else begin
            case (state)
                NORM: begin
                    // The bit about to land in xm[NF] decides whether this is the last shift.
                    xm <= xm << 1;
                    xe <= xe - XEW'(1);
                    if (xm[NF-1]) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign is_zero = cls.is_zero;
    assign is_sub  = cls.is_sub;
    assign is_inf  = cls.is_inf;
    assign is_nan  = cls.is_nan;
    assign is_snan = cls.is_snan;
endmodule

// File: tb/tb_fma16_unpack.sv
// Scoreboard bench for fma16_unpack: directed operands with hand-computed results and latencies.
module tb_fma16_unpack;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;
    logic        xs;
    logic [6:0]  xe;
    logic [10:0] xm;
    logic        is_zero, is_sub, is_inf, is_nan, is_snan;

    typedef struct {
        logic        xs;
        logic [6:0]  xe;
        logic [10:0] xm;
        logic [4:0]  flags;   // {zero, sub, inf, nan, snan}
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   head_seen = 0;

    fma16_unpack dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .xs(xs), .xe(xe), .xm(xm),
        .is_zero(is_zero), .is_sub(is_sub), .is_inf(is_inf), .is_nan(is_nan), .is_snan(is_snan)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic s, input int e, input int m, input logic [4:0] f, input int lat);
        exp_t r;
        r.xs    = s;
        r.xe    = 7'(e);
        r.xm    = 11'(m);
        r.flags = f;
        r.lat   = lat;
        r.acc   = 0;
        return r;
    endfunction

    function automatic int sub_lat(input int k);
`ifdef FMA16_UNPACK_LZC_EN
        return 1 + 0 * k;
`else
        return 1 + k;
`endif
    endfunction

    // Presents one operand at a negedge and returns just after the edge that accepts it.
    task automatic send(input logic [15:0] xv, input exp_t ev, input bit ordy, input bit track,
                        output int waits);
        waits = 0;
        @(negedge clk);
        out_ready = ordy;
        in_valid  = 1'b1;
        x         = xv;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            waits++;
            if (waits > 200) begin
                $display("FAIL accept_timeout: x=0x%h never accepted", xv);
                $display("test done: total=%0d bad=%0d", total, bad + 1);
                $fatal(1);
            end
        end
        ev.acc = cyc + 1;
        if (track) sb.push_back(ev);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            idle(1);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: samples after the drivers have settled each negedge.
    initial begin
        exp_t h;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: xe=0x%h xm=0x%h with no expected result", xe, xm);
                end else begin
                    h = sb[0];
                    if (!head_seen) begin
                        check("latency", cyc - h.acc + 1, h.lat);
                        head_seen = 1;
                    end
                    check("xs", int'(xs), int'(h.xs));
                    check("xe", int'(xe), int'(h.xe));
                    check("xm", int'(xm), int'(h.xm));
                    check("flags", int'({is_zero, is_sub, is_inf, is_nan, is_snan}), int'(h.flags));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        head_seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int w;
        bit track_rst;
        logic [15:0] b2b_x [8];
        exp_t        b2b_e [8];

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_outputs", int'({xs, xe, xm}), 0);
        check("rst_flags", int'({is_zero, is_sub, is_inf, is_nan, is_snan}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Normal and special operands
        send(16'h3C00, mk(0, 0, 'h400, 5'b00000, 1), 1, 1, w);
        send(16'h7E00, mk(0, 16, 'h200, 5'b00010, 1), 1, 1, w);
        send(16'h7C01, mk(0, 16, 'h001, 5'b00011, 1), 1, 1, w);
        send(16'hFC00, mk(1, 16, 'h000, 5'b00100, 1), 1, 1, w);
        send(16'h8000, mk(1, 0, 'h000, 5'b10000, 1), 1, 1, w);
        send(16'h7C00, mk(0, 16, 'h000, 5'b00100, 1), 1, 1, w);

        // Subnormals: k = shifts needed to reach the leading one
        send(16'h0001, mk(0, -24, 'h400, 5'b01000, sub_lat(10)), 1, 1, w);
        send(16'h0200, mk(0, -15, 'h400, 5'b01000, sub_lat(1)), 1, 1, w);
        send(16'h8155, mk(1, -16, 'h554, 5'b01000, sub_lat(2)), 1, 1, w);
        send(16'h03FF, mk(0, -15, 'h7FE, 5'b01000, sub_lat(1)), 1, 1, w);
        drain();

        // Backpressure, then simultaneous transfer and accept
        send(16'h4000, mk(0, 1, 'h400, 5'b00000, 1), 0, 1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("stall_in_ready", int'(in_ready), 0);
        end
        send(16'h3800, mk(0, -1, 'h400, 5'b00000, 1), 1, 1, w);
        drain();

        // Reset while a subnormal is still normalizing
`ifdef FMA16_UNPACK_LZC_EN
        track_rst = 1;
`else
        track_rst = 0;
`endif
        send(16'h0001, mk(0, -24, 'h400, 5'b01000, 1), 1, track_rst, w);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_outputs", int'({xs, xe, xm}), 0);
        check("midrst_flags", int'({is_zero, is_sub, is_inf, is_nan, is_snan}), 0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        head_seen = 0;
        idle(15);
        check("midrst_no_output", int'(out_valid), 0);

        // Back-to-back normals: each must be accepted without waiting
        b2b_x = '{16'h3C00, 16'h4000, 16'h4200, 16'h3800, 16'hC500, 16'h0400, 16'h7BFF, 16'h3555};
        b2b_e[0] = mk(0, 0, 'h400, 5'b00000, 1);
        b2b_e[1] = mk(0, 1, 'h400, 5'b00000, 1);
        b2b_e[2] = mk(0, 1, 'h600, 5'b00000, 1);
        b2b_e[3] = mk(0, -1, 'h400, 5'b00000, 1);
        b2b_e[4] = mk(1, 2, 'h500, 5'b00000, 1);
        b2b_e[5] = mk(0, -14, 'h400, 5'b00000, 1);
        b2b_e[6] = mk(0, 15, 'h7FF, 5'b00000, 1);
        b2b_e[7] = mk(0, -2, 'h555, 5'b00000, 1);
        for (int i = 0; i < 8; i++) begin
            send(b2b_x[i], b2b_e[i], 1, 1, w);
            check("b2b_no_bubble", w, 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
